// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int DEF_HALF_DEF = 250;   // 100 kHz from a 50 MHz clock

    // Channel-index width; a single channel still gets a 1-bit index.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: half-period counter, toggling output, rise tick, and a
// pending half-period that takes effect only at a period boundary.
module clkdiv_ch
    import clkdiv_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] HALF_RST = (DEF_HALF == 0) ? CNT_W'(1) : CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_vld;
    logic             restart;
    logic             tc;
    logic             apply;

    assign restart = ~en | sync;
    assign tc      = (cnt == half - CNT_W'(1));
    // Disable and sync both put the channel at a fresh period start, so a
    // pending value can be taken there without shortening any period.
    assign apply   = pend_vld & (restart | tc);
    assign pend    = pend_vld;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (tc) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

    // A write landing on the same edge as an apply only fills the pending
    // register, so it waits for the following boundary.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            half      <= HALF_RST;
            pend_half <= '0;
            pend_vld  <= 1'b0;
        end else begin
            if (apply) begin
                half <= pend_half;
            end
            if (wr) begin
                pend_half <= (wr_div == '0) ? CNT_W'(1) : wr_div;
                pend_vld  <= 1'b1;
            end else if (apply) begin
                pend_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: configuration decode, write handshake and
// error flag around N_CH independent divider channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int CNT_W    = CNT_W_DEF,
    parameter  int DEF_HALF = DEF_HALF_DEF,
    localparam int IDX_W    = ch_idx_w(N_CH)
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic            accept;
    logic            in_range;
    logic [N_CH-1:0] wr;
    logic [N_CH-1:0] pend;

    // One outstanding write at a time across all channels.
    assign cfg_ready = ~|pend;
    assign accept    = cfg_valid & cfg_ready;
    assign in_range  = (32'(cfg_ch) < 32'(N_CH));

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~in_range;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = accept & in_range & (cfg_ch == IDX_W'(i));

        clkdiv_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_50m (clk_50m),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: a toggle-schedule model predicts every
// clk_out transition and cfg_err pulse; a negedge monitor consumes them.
module tb_clkdiv_multi;

    localparam int N_CH     = 6;
    localparam int CNT_W    = 16;
    localparam int DEF_HALF = 250;
    localparam int IDX_W    = 3;

    logic             clk_50m = 1'b0;
    logic             rst_n   = 1'b0;
    logic [N_CH-1:0]  ch_en   = '0;
    logic             sync    = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_ch  = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_err;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected transitions per channel, encoded as edge*2 + new level.
    int exp_q[N_CH][$];
    int err_q[$];

    int m_anchor[N_CH];
    int m_half[N_CH];
    int m_pend[N_CH];
    bit m_lvl[N_CH];
    bit m_pend_v[N_CH];

    clkdiv_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        for (int i = 0; i < N_CH; i++)
            if (m_pend_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_anchor[i] = 0;
            m_half[i]   = DEF_HALF;
            m_pend[i]   = 0;
            m_lvl[i]    = 1'b0;
            m_pend_v[i] = 1'b0;
            exp_q[i].delete();
        end
        err_q.delete();
        cyc = 0;
    endtask

    // Each channel toggles half edges after its last toggle or restart;
    // restarts (disable, sync) drop the output low; pending values land on
    // any of those boundaries; writes are judged against pre-edge readiness.
    task automatic model_edge(input int e);
        bit rdy;
        bit hit;
        int idx;
        rdy = model_ready();
        for (int i = 0; i < N_CH; i++) begin
            hit = 1'b0;
            if (!ch_en[i] || sync) begin
                if (m_lvl[i]) exp_q[i].push_back(e * 2);
                m_lvl[i]    = 1'b0;
                m_anchor[i] = e;
                hit = 1'b1;
            end else if (e == m_anchor[i] + m_half[i]) begin
                m_lvl[i]    = !m_lvl[i];
                m_anchor[i] = e;
                exp_q[i].push_back(e * 2 + int'(m_lvl[i]));
                hit = 1'b1;
            end
            if (hit && m_pend_v[i]) begin
                m_half[i]   = m_pend[i];
                m_pend_v[i] = 1'b0;
            end
        end
        if (cfg_valid && rdy) begin
            idx = int'(cfg_ch);
            if (idx < N_CH) begin
                m_pend_v[idx] = 1'b1;
                m_pend[idx]   = (cfg_div == '0) ? 1 : int'(cfg_div);
            end else begin
                err_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        model_edge(cyc + 1);
        @(posedge clk_50m);
        cyc++;
        #1;
        check("cfg_ready", int'(cfg_ready), int'(model_ready()));
        cfg_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int div);
        cfg_ch    = IDX_W'(ch);
        cfg_div   = CNT_W'(div);
        cfg_valid = 1'b1;
        step();
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!model_ready() && k < 2000) begin
            step();
            k++;
        end
        if (!model_ready()) begin
            checks++;
            failures++;
            $display("FAIL wait_ready: pending never applied within %0d cycles", k);
        end
    endtask

    task automatic release_reset();
        @(posedge clk_50m);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: consumes expected transitions whenever the DUT shows one.
    initial begin
        logic [N_CH-1:0] prev;
        int ev;
        int exp_t;
        prev = '0;
        forever begin
            @(negedge clk_50m);
            if (!rst_n) begin
                prev = '0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (clk_out[i] != prev[i]) begin
                        checks++;
                        if (exp_q[i].size() == 0) begin
                            failures++;
                            $display("FAIL clk_out_edge ch%0d: got level %0d at cycle %0d, required no transition",
                                     i, clk_out[i], cyc);
                        end else begin
                            ev = exp_q[i].pop_front();
                            if (ev != cyc * 2 + int'(clk_out[i])) begin
                                failures++;
                                $display("FAIL clk_out_edge ch%0d: got level %0d at cycle %0d, required level %0d at cycle %0d",
                                         i, clk_out[i], cyc, ev % 2, ev / 2);
                            end
                        end
                    end
                    checks++;
                    if (tick[i] !== (clk_out[i] & ~prev[i])) begin
                        failures++;
                        $display("FAIL tick ch%0d: got %0d required %0d at cycle %0d",
                                 i, tick[i], clk_out[i] & ~prev[i], cyc);
                    end
                end
                if (cfg_err) begin
                    checks++;
                    if (err_q.size() == 0) begin
                        failures++;
                        $display("FAIL cfg_err: got pulse at cycle %0d, required none", cyc);
                    end else begin
                        exp_t = err_q.pop_front();
                        if (exp_t != cyc) begin
                            failures++;
                            $display("FAIL cfg_err: got pulse at cycle %0d, required at cycle %0d", cyc, exp_t);
                        end
                    end
                end
                prev = clk_out;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_cfg_err", int'(cfg_err), 0);

        // Defaults: every channel toggles every 250 cycles.
        ch_en = '1;
        release_reset();
        repeat (1100) step();

        // Mid-period retune of ch1: current half completes, then 5-cycle halves.
        write_cfg(1, 5);
        check("ready_low_after_write", int'(cfg_ready), 0);
        repeat (300) step();

        // Zero divisor behaves as divide-by-2.
        write_cfg(3, 0);
        repeat (300) step();

        // Out-of-range channel: error pulse only.
        write_cfg(7, 100);
        check("ready_after_bad_ch", int'(cfg_ready), 1);
        repeat (3) step();
        write_cfg(6, 3);
        repeat (3) step();

        // Two channels with equal half started out of phase, then realigned.
        wait_ready();
        write_cfg(0, 3);
        wait_ready();
        write_cfg(2, 3);
        wait_ready();
        ch_en[0] = 1'b0;
        ch_en[2] = 1'b0;
        repeat (2) step();
        ch_en[0] = 1'b1;
        repeat (2) step();
        ch_en[2] = 1'b1;
        repeat (7) step();
        sync = 1'b1;
        step();
        repeat (3) step();
        check("sync_ch0_high", int'(clk_out[0]), 1);
        check("sync_ch2_high", int'(clk_out[2]), 1);
        check("sync_ch0_tick", int'(tick[0]), 1);
        check("sync_ch2_tick", int'(tick[2]), 1);

        // Randomized enables, syncs and writes (including bad channels).
        repeat (4000) begin
            if ($urandom_range(0, 299) == 0) ch_en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) sync = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = IDX_W'($urandom_range(0, 7));
                cfg_div   = CNT_W'($urandom_range(0, 12));
            end
            step();
        end

        // Reset with a write pending and enables wiggling.
        ch_en = '1;
        wait_ready();
        write_cfg(0, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", int'(clk_out), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_cfg_err", int'(cfg_err), 0);
        check("async_rst_cfg_ready", int'(cfg_ready), 1);
        repeat (4) begin
            @(posedge clk_50m);
            #1;
            ch_en = N_CH'($urandom);
        end
        ch_en = '1;
        release_reset();
        repeat (600) step();

        @(negedge clk_50m);
        #1;
        for (int i = 0; i < N_CH; i++)
            check($sformatf("leftover_edges_ch%0d", i), exp_q[i].size(), 0);
        check("leftover_cfg_err", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
